// File: rtl/uart_pkg.sv
// Shared UART definitions: clock/baud defaults, bit-period computation and FSM states.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEFAULT_FREQ = 12_000_000;
    localparam int DEFAULT_BAUD = 9600;
    localparam int CNT_W        = 11;

    function automatic int calc_lim(input int freq, input int baud);
        return freq / baud;
    endfunction

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..LIM-1 while enabled and pulses bit_tick on the last count.
// A clear restarts the period so a new frame always begins on a full bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int LIM = calc_lim(DEFAULT_FREQ, DEFAULT_BAUD)
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic en,
    output logic bit_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIM - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!nrst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and a registered serial line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FREQ = DEFAULT_FREQ,
    parameter int BAUD = DEFAULT_BAUD
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy
);

    localparam int LIM = calc_lim(FREQ, BAUD);

    uart_state_t state;
    logic [7:0]  shreg;
    logic [3:0]  bit_idx;
    logic        bit_tick;
    logic        accept;
    logic        baud_en;
`ifdef UART_TX_PARITY_EN
    logic        par_bit;
`endif

    assign accept  = tx_valid && tx_ready;
    assign baud_en = (state != IDLE);
    assign tx_busy = !tx_ready;

    uart_baud_gen #(
        .LIM(LIM)
    ) u_baud_gen (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (accept),
        .en      (baud_en),
        .bit_tick(bit_tick)
    );

    // Each state drives the line value for the following bit, so tx_out changes only on ticks.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            tx_out   <= 1'b1;
            tx_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= tx_data;
                        bit_idx  <= '0;
                        tx_out   <= 1'b0;
                        tx_ready <= 1'b0;
                        state    <= START;
`ifdef UART_TX_PARITY_EN
                        par_bit  <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx_out <= shreg[0];
                        shreg  <= {1'b0, shreg[7:1]};
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == 4'd7) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_out  <= par_bit;
                            state   <= PARITY;
`else
                            tx_out  <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            tx_out  <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        tx_out <= 1'b1;
                        state  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick) begin
                        tx_out   <= 1'b1;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tx_out   <= 1'b1;
                    tx_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at default FREQ/BAUD (1250 clocks per bit).
// Expectations follow UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx;

    localparam int LIM = 1250;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * LIM;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       tx_busy;

    int vectors     = 0;
    int miscompares = 0;

    uart_tx dut (
        .clk     (clk),
        .nrst    (nrst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_out  (tx_out),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Called on a negedge while idle; returns on the negedge of the first start-bit cycle.
    task automatic applyStimulus(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Walks a whole frame from its first cycle, one check per bit window, then checks the idle cycle.
    task automatic checkFrame(input logic [7:0] b, input string tag);
        logic [10:0] exp_bits;
        int good;
        int busy_cycles;
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = ^b;
`endif
        busy_cycles = 0;
        for (int k = 0; k < NBITS; k++) begin
            good = 0;
            for (int c = 0; c < LIM; c++) begin
                if (tx_out === exp_bits[k]) good++;
                if (tx_ready === 1'b0 && tx_busy === 1'b1) busy_cycles++;
                @(negedge clk);
            end
            checkOutput($sformatf("%s bit%0d", tag, k), good, LIM);
        end
        checkOutput({tag, " busy_cycles"}, busy_cycles, FRAME);
        checkOutput({tag, " ready_after"}, int'(tx_ready), 1);
        checkOutput({tag, " line_after"}, int'(tx_out), 1);
    endtask

    task automatic checkIdle(input int cycles, input string tag);
        int good;
        good = 0;
        for (int c = 0; c < cycles; c++) begin
            if (tx_out === 1'b1 && tx_ready === 1'b1 && tx_busy === 1'b0) good++;
            @(negedge clk);
        end
        checkOutput(tag, good, cycles);
    endtask

    initial begin
        nrst     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset tx_out", int'(tx_out), 1);
        checkOutput("reset tx_ready", int'(tx_ready), 1);
        checkOutput("reset tx_busy", int'(tx_busy), 0);
        nrst = 1'b1;
        @(negedge clk);

        checkIdle(20000, "idle 20000");

        applyStimulus(8'h55);
        checkFrame(8'h55, "x55");

        // 0xFF pulsed mid-frame must be ignored and must not disturb the latched 0xA3.
        applyStimulus(8'hA3);
        fork
            checkFrame(8'hA3, "xA3");
            begin
                repeat (3000) @(negedge clk);
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        checkIdle(100, "no xFF frame");

        // tx_valid held across frames: second start bit follows a single idle cycle.
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'h80;
        checkFrame(8'h01, "x01");
        @(negedge clk);
        tx_valid = 1'b0;
        checkFrame(8'h80, "x80");

        applyStimulus(8'h3C);
        repeat (5000) @(negedge clk);
        checkOutput("x3C midframe busy", int'(tx_busy), 1);
        nrst     = 1'b0;
        tx_data  = 8'h0F;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort tx_out", int'(tx_out), 1);
        checkOutput("abort tx_ready", int'(tx_ready), 1);
        checkOutput("abort tx_busy", int'(tx_busy), 0);
        repeat (3) @(negedge clk);
        checkOutput("valid in reset ignored", int'(tx_out & tx_ready), 1);
        nrst = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checkFrame(8'h0F, "x0F");

`ifdef UART_TX_PARITY_EN
        applyStimulus(8'h07);
        checkFrame(8'h07, "x07");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
